// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared constants and the source-hazard helper for the pipeline
//            stall controller.
// Contents : MULT_CYCLES_DEF, DIV_CYCLES_DEF  - default mult/div busy lengths
//            TUSE_NONE                        - Tuse encoding for "unused"
//            REG_AW                           - register index width
//            src_hazard()                     - one source vs one producer
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam logic [1:0]  TUSE_NONE       = 2'd3;
  localparam int unsigned REG_AW          = 5;

  // A source hazards against a producer when both name the same non-zero
  // register and the result arrives later than the consumer needs it.
  // A Tuse of TUSE_NONE can never be exceeded by a 2-bit Tnew, so an unused
  // source drops out without any special casing.
  function automatic logic src_hazard(
    input logic [REG_AW-1:0] src,
    input logic [1:0]        tuse,
    input logic [REG_AW-1:0] wa,
    input logic [1:0]        tnew
  );
    return (src != '0) && (src == wa) && (tnew > tuse);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_counter
// Purpose  : Tracks the multiply/divide unit busy window with a countdown.
//            busy is high in the start cycle and the N cycles that follow.
// Ports    : clk    in  - clock
//            reset  in  - asynchronous active-high reset
//            start  in  - mult/div issued this cycle
//            is_div in  - 1 = divide, 0 = multiply (qualifies start)
//            busy   out - unit busy
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_nz;

  assign w_cnt_nz = (r_cnt != '0);

  // A start while the count is running is an upstream error and is ignored
  // so the window in progress is not stretched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start && !w_cnt_nz) begin
      r_cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (w_cnt_nz) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // start is folded in combinationally so the issue cycle itself is busy.
  assign busy = start | w_cnt_nz;

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Hazard/stall controller. Drives the PC and F/D enables (also
//            pipeline_cmp.en) and the D/E bubble insert, from Tuse/Tnew
//            register hazards and the mult/div busy window.
// Ports    : clk, reset                    - clock, async active-high reset
//            d_rs_addr/d_rt_addr           - D source register indices
//            d_tuse_rs/d_tuse_rt           - D source Tuse (3 = unused)
//            d_is_md                       - D instruction uses mult/div unit
//            e_wa/e_tnew, m_wa/m_tnew      - pending destinations in E and M
//            e_md_start, e_md_div          - mult/div issue from E
//            en_pc, en_fd, clr_de          - pipeline register controls
//            md_busy, stall                - status
//            stall_cycles                  - stall counter (PIPE_STALL_STAT_EN)
// Options  : PIPE_STALL_STAT_EN - adds the 32-bit stall_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs_addr,
  input  logic [REG_AW-1:0] d_rt_addr,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic              d_is_md,
  input  logic [REG_AW-1:0] e_wa,
  input  logic [1:0]        e_tnew,
  input  logic [REG_AW-1:0] m_wa,
  input  logic [1:0]        m_tnew,
  input  logic              e_md_start,
  input  logic              e_md_div,
  output logic              en_pc,
  output logic              en_fd,
  output logic              clr_de,
  output logic              md_busy,
  output logic              stall
`ifdef PIPE_STALL_STAT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic w_rs_hz;
  logic w_rt_hz;
  logic w_md_hz;
  logic w_md_busy;
  logic w_stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_div),
    .busy   (w_md_busy)
  );

  assign w_rs_hz = src_hazard(d_rs_addr, d_tuse_rs, e_wa, e_tnew) |
                   src_hazard(d_rs_addr, d_tuse_rs, m_wa, m_tnew);
  assign w_rt_hz = src_hazard(d_rt_addr, d_tuse_rt, e_wa, e_tnew) |
                   src_hazard(d_rt_addr, d_tuse_rt, m_wa, m_tnew);
  assign w_md_hz = d_is_md & w_md_busy;

  assign w_stall = w_rs_hz | w_rt_hz | w_md_hz;

  // Freeze F and D, and turn what would have entered E into a bubble.
  assign stall   = w_stall;
  assign en_pc   = ~w_stall;
  assign en_fd   = ~w_stall;
  assign clr_de  = w_stall;
  assign md_busy = w_md_busy;

`ifdef PIPE_STALL_STAT_EN
  logic [31:0] r_stall_cycles;

  // Free-running; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Directed self-checking bench for pipe_stall_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs_addr;
  logic [4:0] d_rt_addr;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic       d_is_md;
  logic [4:0] e_wa;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  logic       e_md_start;
  logic       e_md_div;
  logic       en_pc;
  logic       en_fd;
  logic       clr_de;
  logic       md_busy;
  logic       stall;
`ifdef PIPE_STALL_STAT_EN
  logic [31:0] stall_cycles;
`endif

  int n_cmp;
  int n_err;

  pipe_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_is_md    (d_is_md),
    .e_wa       (e_wa),
    .e_tnew     (e_tnew),
    .m_wa       (m_wa),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .en_pc      (en_pc),
    .en_fd      (en_fd),
    .clr_de     (clr_de),
    .md_busy    (md_busy),
    .stall      (stall)
`ifdef PIPE_STALL_STAT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_rs_addr  = '0;
    d_rt_addr  = '0;
    d_tuse_rs  = 2'd3;
    d_tuse_rt  = 2'd3;
    d_is_md    = 1'b0;
    e_wa       = '0;
    e_tnew     = '0;
    m_wa       = '0;
    m_tnew     = '0;
    e_md_start = 1'b0;
    e_md_div   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Checks the combinational control outputs for one expected stall value.
  task automatic chk_stall(input string tag, input logic exp);
    #1;
    chk({tag, ".stall"},  {31'd0, stall},  {31'd0, exp});
    chk({tag, ".clr_de"}, {31'd0, clr_de}, {31'd0, exp});
    chk({tag, ".en_pc"},  {31'd0, en_pc},  {31'd0, ~exp});
    chk({tag, ".en_fd"},  {31'd0, en_fd},  {31'd0, ~exp});
  endtask

  // One-cycle mult/div start with a dependent md instruction held in D;
  // busy and stall are expected for exactly n+1 cycles.
  task automatic md_window(input string tag, input logic is_div, input int n);
    chk({tag, ".idle_before_start"}, {31'd0, md_busy}, 32'd0);
    d_is_md    = 1'b1;
    e_md_start = 1'b1;
    e_md_div   = is_div;
    #1;
    chk({tag, ".busy0"},  {31'd0, md_busy}, 32'd1);
    chk({tag, ".stall0"}, {31'd0, stall},   32'd1);
    step();
    e_md_start = 1'b0;
    e_md_div   = 1'b0;
    for (int i = 1; i <= n + 2; i++) begin
      #1;
      chk($sformatf("%s.busy%0d", tag, i),  {31'd0, md_busy}, (i <= n) ? 32'd1 : 32'd0);
      chk($sformatf("%s.stall%0d", tag, i), {31'd0, stall},   (i <= n) ? 32'd1 : 32'd0);
      step();
    end
    d_is_md = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b1;
    do_reset();

    // Reset state with all inputs idle.
    d_tuse_rs = '0;
    d_tuse_rt = '0;
    chk_stall("reset", 1'b0);
    chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
`ifdef PIPE_STALL_STAT_EN
    chk("reset.stall_cycles", stall_cycles, 32'd0);
`endif

    // rs against E: result two cycles out, needed now.
    clear_inputs();
    d_rs_addr = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd2;
    chk_stall("rs_e_hz", 1'b1);
    // Register 0 never hazards.
    d_rs_addr = 5'd0; e_wa = 5'd0;
    chk_stall("rs_zero", 1'b0);

    // rt against M: Tnew == Tuse is fine, Tnew > Tuse stalls.
    clear_inputs();
    d_rt_addr = 5'd9; d_tuse_rt = 2'd1; m_wa = 5'd9; m_tnew = 2'd1;
    chk_stall("rt_m_eq", 1'b0);
    m_tnew = 2'd2;
    chk_stall("rt_m_gt", 1'b1);

    // Different registers do not hazard.
    m_wa = 5'd10;
    chk_stall("rt_m_diff", 1'b0);

    // Tuse of 3 compares normally: Tnew 3 cannot exceed it.
    clear_inputs();
    d_rt_addr = 5'd4; d_tuse_rt = 2'd3; e_wa = 5'd4; e_tnew = 2'd3;
    chk_stall("rt_e_tuse3", 1'b0);
    d_tuse_rt = 2'd2;
    chk_stall("rt_e_tnew3", 1'b1);

    // rs against M.
    clear_inputs();
    d_rs_addr = 5'd31; d_tuse_rs = 2'd1; m_wa = 5'd31; m_tnew = 2'd3;
    chk_stall("rs_m_hz", 1'b1);

    // Multiply and divide busy windows.
    clear_inputs();
    step();
    md_window("mult", 1'b0, 5);
    md_window("div", 1'b1, 10);

    // Busy unit without a dependent md instruction in D does not stall.
    clear_inputs();
    e_md_start = 1'b1;
    #1;
    chk("busy_no_md.busy",  {31'd0, md_busy}, 32'd1);
    chk("busy_no_md.stall", {31'd0, stall},   32'd0);
    step();
    e_md_start = 1'b0;
    repeat (7) step();

    // Reset mid-divide clears busy at once.
    clear_inputs();
    d_is_md = 1'b1;
    e_md_start = 1'b1; e_md_div = 1'b1;
    step();
    e_md_start = 1'b0; e_md_div = 1'b0;
    step();
    step();
    #1;
    chk("rst_mid.busy_before", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.busy_now",  {31'd0, md_busy}, 32'd0);
    chk("rst_mid.stall_now", {31'd0, stall},   32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_mid.after%0d", i), {31'd0, stall}, 32'd0);
    end
    d_is_md = 1'b0;

`ifdef PIPE_STALL_STAT_EN
    // Four hazard cycles counted.
    do_reset();
    clear_inputs();
    chk("stat.cleared", stall_cycles, 32'd0);
    d_rs_addr = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd2;
    repeat (4) step();
    clear_inputs();
    step();
    chk("stat.count4", stall_cycles, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
